display_bitboard_grid: RTL

Simulation/debug printer for the move generator. It captures NUM_BOARDS 64-bit bitboards (attack maps, occupancy, pin masks) and renders them side by side as an ASCII grid, one character per cycle. Output goes to a char_out/char_valid/char_ready stream for a UART or bench checker, and is optionally echoed through $write. It generalises the single-board attack display with multiple boards, a flip mode, coordinate labels, backpressure and a capture handshake.

---
 rtl/display_bitboard_grid.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/display_bitboard_grid.sv
// Renders NUM_BOARDS captured bitboards as an ASCII grid,
// one character per cycle on a valid/ready byte stream.
module display_bitboard_grid #(
  parameter int          NUM_BOARDS  = 2,
  parameter logic [63:0] TITLE       = 64'h00_41_74_74_61_63_6B_73,
  parameter bit          FLIP        = 1'b0,
  parameter bit          SHOW_COORDS = 1'b1,
  parameter bit          ECHO        = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [64*NUM_BOARDS-1:0] boards,
  input  logic                    boards_valid,
  output logic                    ready,
  output logic                    busy,
  output logic [7:0]              char_out,
  output logic                    char_valid,
  input  logic                    char_ready,
  output logic                    display_done
);

  localparam int BW = $clog2(NUM_BOARDS) + 1;
  localparam int IW = $clog2(64 * NUM_BOARDS);
  localparam logic [BW-1:0] BLAST = BW'(NUM_BOARDS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_TITLE, S_TNL, S_RLAB, S_SQ, S_SEP,
    S_EOL, S_FPRE, S_FLET, S_FSEP, S_FNL, S_BLANK
  } state_e;

  state_e                   state_q, st_d, line0;
  logic                     ph_q, ph_d;
  logic [2:0]               tb_q, tb_d;
  logic [2:0]               rank_q, rank_d;
  logic [2:0]               file_q, file_d;
  logic [BW-1:0]            brd_q, brd_d;
  logic [64*NUM_BOARDS-1:0] boards_q, src;
  logic [7:0]               char_q, char_d;
  logic                     cvalid_q, busy_q, ready_q, done_q;
  logic                     last, adv;
  logic [3:0]               tsel;
  logic [2:0]               rk_eff, fl_eff;
  logic [IW-1:0]            idx;
  logic [63:0]              tsh;

  // Bit 3 set in the result means no non-NUL title byte at or after 'from'.
  function automatic logic [3:0] title_from(input logic [3:0] from);
    logic [3:0] r;
    r = 4'h8;
    for (int i = 7; i >= 0; i--)
      if (i >= int'(from) && TITLE[8*(7-i) +: 8] != 8'h00)
        r = 4'(i);
    return r;
  endfunction

  // Next output position: start position when idle, else successor.
  always_comb begin
    st_d   = state_q;
    ph_d   = 1'b0;
    tb_d   = tb_q;
    rank_d = rank_q;
    file_d = file_q;
    brd_d  = brd_q;
    last   = 1'b0;
    tsel   = 4'h0;
    if (SHOW_COORDS) line0 = S_RLAB;
    else             line0 = S_SQ;
    if (!busy_q) begin
      tsel   = title_from(4'd0);
      tb_d   = tsel[2:0];
      rank_d = 3'd0;
      file_d = 3'd0;
      brd_d  = '0;
      st_d   = tsel[3] ? line0 : S_TITLE;
    end else begin
      unique case (state_q)
        S_TITLE: begin
          tsel = title_from({1'b0, tb_q} + 4'd1);
          tb_d = tsel[2:0];
          st_d = tsel[3] ? S_TNL : S_TITLE;
        end
        S_TNL: st_d = line0;
        S_RLAB, S_FPRE: begin
          if (!ph_q) ph_d = 1'b1;
          else begin
            st_d   = (state_q == S_RLAB) ? S_SQ : S_FLET;
            file_d = 3'd0;
            brd_d  = '0;
          end
        end
        S_SQ, S_FLET: begin
          if (!ph_q) ph_d = 1'b1;
          else if (file_q != 3'd7) file_d = file_q + 3'd1;
          else if (brd_q != BLAST) begin
            st_d   = (state_q == S_SQ) ? S_SEP : S_FSEP;
            file_d = 3'd0;
          end else
            st_d = (state_q == S_SQ) ? S_EOL : S_FNL;
        end
        S_SEP, S_FSEP: begin
          if (!ph_q) ph_d = 1'b1;
          else begin
            st_d  = (state_q == S_SEP) ? S_SQ : S_FLET;
            brd_d = brd_q + BW'(1);
          end
        end
        S_EOL: begin
          if (rank_q != 3'd7) begin
            rank_d = rank_q + 3'd1;
            file_d = 3'd0;
            brd_d  = '0;
            st_d   = line0;
          end else
            st_d = SHOW_COORDS ? S_FPRE : S_BLANK;
        end
        S_FNL: st_d = S_BLANK;
        S_BLANK: begin
          st_d   = S_IDLE;
          tb_d   = 3'd0;
          rank_d = 3'd0;
          file_d = 3'd0;
          brd_d  = '0;
          last   = 1'b1;
        end
        default: st_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    rk_eff = FLIP ? rank_d : ~rank_d;
    fl_eff = FLIP ? ~file_d : file_d;
    src    = busy_q ? boards_q : boards;
    idx    = IW'({brd_d, rk_eff, fl_eff});
    tsh    = TITLE << {tb_d, 3'b000};
    char_d = 8'h00;
    unique case (st_d)
      S_TITLE: char_d = tsh[63:56];
      S_TNL, S_EOL, S_FNL, S_BLANK: char_d = 8'h0A;
      S_RLAB:  char_d = ph_d ? 8'h20 : 8'h31 + {5'd0, rk_eff};
      S_SQ:    char_d = ph_d ? 8'h20 : (src[idx] ? 8'h58 : 8'h2E);
      S_SEP:   char_d = ph_d ? 8'h20 : 8'h7C;
      S_FPRE, S_FSEP: char_d = 8'h20;
      S_FLET:  char_d = ph_d ? 8'h20 : 8'h61 + {5'd0, fl_eff};
      default: char_d = 8'h00;
    endcase
  end

  assign adv = busy_q ? char_ready : boards_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ph_q     <= 1'b0;
      tb_q     <= 3'd0;
      rank_q   <= 3'd0;
      file_q   <= 3'd0;
      brd_q    <= '0;
      boards_q <= '0;
      char_q   <= 8'h00;
      cvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!busy_q && boards_valid) boards_q <= boards;
      if (adv) begin
        state_q  <= st_d;
        ph_q     <= ph_d;
        tb_q     <= tb_d;
        rank_q   <= rank_d;
        file_q   <= file_d;
        brd_q    <= brd_d;
        char_q   <= last ? 8'h00 : char_d;
        cvalid_q <= !last;
        busy_q   <= !last;
        ready_q  <= last;
        done_q   <= last;
      end
    end
  end

  assign ready        = ready_q;
  assign busy         = busy_q;
  assign char_out     = char_q;
  assign char_valid   = cvalid_q;
  assign display_done = done_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (ECHO && !reset && cvalid_q && char_ready)
      $write("%c", char_q);
  end
`endif

endmodule
